// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch-address generator, in-order
// response capture into a DEPTH-entry FIFO, valid/ready delivery to decode,
// and redirect flush with discard of stale in-flight responses.
// Optional macro FETCHQ_BYPASS_EN: when the queue is empty and decode is
// ready, a fresh response is forwarded combinationally to the decode outputs.
module instr_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic [63:0] pc_plus4_o,
    input  logic        ready_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      instr_mem_q [DEPTH];
    logic [63:0]      pc_mem_q    [DEPTH];
    logic [63:0]      fpc_q, fpc_d, rpc_q, rpc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, osd_q, osd_d, dsc_q, dsc_d;
    logic [CNT_W:0]   credit;
    logic [63:0]      redirect_tgt;
    logic             req, gnt_fire, empty, push, pop, bypass;
    logic [31:0]      instr_out;
    logic [63:0]      pc_out;

    // Every granted request must have a FIFO slot reserved for its response.
    assign credit       = {1'b0, count_q} + {1'b0, osd_q};
    assign empty        = (count_q == '0);
    assign req          = rst & ~redirect_i & (credit < DEPTH_C) & (osd_q < MAXO_C);
    assign gnt_fire     = req & imem_gnt_i;
    assign redirect_tgt = redirect_pc_i & ~64'd3;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = rst & empty & (dsc_q == '0) & ~redirect_i & imem_rvalid_i & ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = ~redirect_i & imem_rvalid_i & (dsc_q == '0) & ~bypass;
    assign pop  = ~redirect_i & ~empty & ready_i;

    assign imem_req_o  = req;
    assign imem_addr_o = fpc_q;

    // Next-state: redirect overrides all; stale responses are counted off via dsc.
    always_comb begin
        fpc_d    = fpc_q;
        rpc_d    = rpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dsc_d    = dsc_q;
        case ({gnt_fire, imem_rvalid_i})
            2'b10:   osd_d = osd_q + CNT_W'(1);
            2'b01:   osd_d = osd_q - CNT_W'(1);
            default: osd_d = osd_q;
        endcase
        if (redirect_i) begin
            fpc_d    = redirect_tgt;
            rpc_d    = redirect_tgt;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            dsc_d    = osd_d;
        end else begin
            if (gnt_fire) fpc_d = fpc_q + 64'd4;
            if (imem_rvalid_i) begin
                if (dsc_q != '0) dsc_d = dsc_q - CNT_W'(1);
                else             rpc_d = rpc_q + 64'd4;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q    <= RESET_PC;
            rpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            osd_q    <= '0;
            dsc_q    <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rpc_q    <= rpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            osd_q    <= osd_d;
            dsc_q    <= dsc_d;
        end
    end

    // FIFO storage; contents are only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= rpc_q;
        end
    end

    // Decode-side outputs; an empty queue shows zero and the next expected PC.
    always_comb begin
        instr_out = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
        pc_out    = empty ? rpc_q : pc_mem_q[rd_ptr_q];
        if (bypass) begin
            instr_out = imem_rdata_i;
            pc_out    = rpc_q;
        end
    end

    assign valid_o    = ~empty | bypass;
    assign instr_o    = instr_out;
    assign pc_o       = pc_out;
    assign pc_plus4_o = pc_out + 64'd4;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: queue-based reference model,
// in-order variable-latency memory, directed scenarios and randomized run.
module tb_instr_prefetch_queue;
    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [63:0] RST_PC  = 64'h0;
`ifdef FETCHQ_BYPASS_EN
    localparam int RESP_LAT = 0;
`else
    localparam int RESP_LAT = 1;
`endif
    localparam int FIRST_VALID = 1 + RESP_LAT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic [63:0] pc_plus4_o;
    logic        ready_i = 1'b0;

    instr_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] addr; int due; logic stale; } req_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;

    req_t mq[$];            // granted, not yet returned (memory + model view)
    ent_t fq[$];            // entries decode should see, oldest first
    logic [63:0] fpc_m = RST_PC;
    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    int gnt_prob = 100, rv_prob = 100, lat_min = 1, lat_max = 1, rdy_prob = 100;
    bit m_req, m_byp;
    req_t m_r;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic bit model_req();
        return !redirect_i && (fq.size() + mq.size() < DEPTH) && (mq.size() < MAX_OUT);
    endfunction

    function automatic bit model_byp();
`ifdef FETCHQ_BYPASS_EN
        return fq.size() == 0 && !redirect_i && imem_rvalid_i && ready_i
               && mq.size() != 0 && !mq[0].stale;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: advance queues by the handshakes of the cycle just ended.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            mq.delete();
            fpc_m = RST_PC;
        end else begin
            m_req = model_req();
            m_byp = model_byp();
            if (imem_rvalid_i && mq.size() != 0) m_r = mq.pop_front();
            else m_r = '0;
            if (redirect_i) begin
                fq.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
                fpc_m = redirect_pc_i & ~64'd3;
            end else begin
                if (fq.size() != 0 && ready_i) void'(fq.pop_front());
                if (imem_rvalid_i && !m_r.stale && !m_byp)
                    fq.push_back('{pc: m_r.addr, instr: word(m_r.addr)});
                if (m_req && imem_gnt_i) begin
                    mq.push_back('{addr: fpc_m, due: cyc + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
                    fpc_m = fpc_m + 64'd4;
                end
            end
        end
        cyc++;
    end

    // Compare process: every output checked each cycle against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req", imem_req_o, 0);
            chk("rst_valid", valid_o, 0);
            chk("rst_instr", instr_o, 0);
            chk("rst_pc", pc_o, RST_PC);
            chk("rst_pc4", pc_plus4_o, RST_PC + 64'd4);
        end else begin
            chk("req", imem_req_o, model_req());
            chk("addr", imem_addr_o, fpc_m);
            if (model_byp()) begin
                chk("byp_valid", valid_o, 1);
                chk("byp_pc", pc_o, mq[0].addr);
                chk("byp_instr", instr_o, word(mq[0].addr));
                chk("byp_pc4", pc_plus4_o, mq[0].addr + 64'd4);
            end else begin
                chk("valid", valid_o, fq.size() != 0);
                if (fq.size() != 0) begin
                    chk("pc", pc_o, fq[0].pc);
                    chk("instr", instr_o, fq[0].instr);
                    chk("pc4", pc_plus4_o, fq[0].pc + 64'd4);
                end
            end
        end
    end

    task automatic drive_inputs(input bit redir, input logic [63:0] tgt);
        redirect_i    = redir;
        redirect_pc_i = redir ? tgt : {$urandom, $urandom};
        ready_i       = ($urandom_range(99) < rdy_prob);
        imem_gnt_i    = ($urandom_range(99) < gnt_prob);
        if (mq.size() != 0 && mq[0].due <= cyc && $urandom_range(99) < rv_prob) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word(mq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    task automatic tick(input bit redir, input logic [63:0] tgt);
        @(posedge clk); #1;
        drive_inputs(redir, tgt);
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_inputs(1'b0, 64'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; ready_i = 1'b0;
        #1;
        chk("rst_now_req", imem_req_o, 0);
        chk("rst_now_valid", valid_o, 0);
        chk("rst_now_instr", instr_o, 0);
        chk("rst_now_pc", pc_o, RST_PC);
        chk("rst_now_pc4", pc_plus4_o, RST_PC + 64'd4);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            tick(1'b0, 64'h0);
        end
        chk(nm, found, 1);
    endtask

    function automatic logic [63:0] rand_target();
        case ($urandom_range(2))
            0:       return {$urandom, $urandom};
            1:       return 64'h1000 + 64'($urandom_range(255));
            default: return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
        endcase
    endfunction

    initial begin
        int nrv;
        // 1: streaming fetch, grant always, 1-cycle memory latency
        gnt_prob = 100; rv_prob = 100; lat_min = 1; lat_max = 1; rdy_prob = 100;
        do_reset(); release_rst();
        chk("t1_req0", imem_req_o, 1);
        chk("t1_addr0", imem_addr_o, 64'h0);
        for (int c = 1; c <= FIRST_VALID + 3; c++) begin
            tick(1'b0, 64'h0);
            if (c < FIRST_VALID) chk("t1_not_yet_valid", valid_o, 0);
            else begin
                chk("t1_valid", valid_o, 1);
                chk("t1_pc_seq", pc_o, 64'((c - FIRST_VALID) * 4));
            end
        end

        // 2: decode stall fills the queue, then drains in order
        rdy_prob = 0;
        do_reset(); release_rst();
        repeat (9) tick(1'b0, 64'h0);
        chk("t2_full_valid", valid_o, 1);
        chk("t2_full_noreq", imem_req_o, 0);
        chk("t2_full_pc", pc_o, 64'h0);
        rdy_prob = 100;
        tick(1'b0, 64'h0);
        chk("t2_c10_noreq", imem_req_o, 0);
        chk("t2_c10_addr", imem_addr_o, 64'h10);
        chk("t2_c10_pc", pc_o, 64'h0);
        tick(1'b0, 64'h0);
        chk("t2_c11_pc", pc_o, 64'h4);
        chk("t2_c11_req", imem_req_o, 1);
        chk("t2_c11_addr", imem_addr_o, 64'h10);
        tick(1'b0, 64'h0); chk("t2_c12_pc", pc_o, 64'h8);
        tick(1'b0, 64'h0); chk("t2_c13_pc", pc_o, 64'hC);
        tick(1'b0, 64'h0); chk("t2_c14_pc", pc_o, 64'h10);

        // 3: redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        do_reset(); release_rst();
        tick(1'b0, 64'h0);
        tick(1'b1, 64'h1002);
        chk("t3_redir_noreq", imem_req_o, 0);
        tick(1'b0, 64'h0);
        chk("t3_new_addr", imem_addr_o, 64'h1000);
        nrv = 0;
        for (int i = 0; i < 30 && !valid_o; i++) begin
            if (imem_rvalid_i) nrv++;
            tick(1'b0, 64'h0);
        end
        chk("t3_valid_seen", valid_o, 1);
        chk("t3_rvalid_before", 64'(nrv), 64'(2 + RESP_LAT));
        chk("t3_first_pc", pc_o, 64'h1000);
        chk("t3_first_instr", instr_o, word(64'h1000));

        // 4: second redirect while one stale response remains, coinciding with it
        lat_min = 1; lat_max = 1; rv_prob = 0;
        do_reset(); release_rst();
        tick(1'b0, 64'h0);
        tick(1'b1, 64'h1002);
        rv_prob = 100;
        tick(1'b0, 64'h0);
        tick(1'b1, 64'h2000);
        wait_valid("t4_valid_seen", 20);
        chk("t4_first_pc", pc_o, 64'h2000);
        chk("t4_first_instr", instr_o, word(64'h2000));

        // 5: fetch address wraps at 2^64
        do_reset(); release_rst();
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1'b0, 64'h0);
        chk("t5_addr_top", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_req_top", imem_req_o, 1);
        tick(1'b0, 64'h0);
        chk("t5_addr_wrap", imem_addr_o, 64'h0);
        wait_valid("t5_valid_seen", 20);
        chk("t5_pc_top", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc4_wrap", pc_plus4_o, 64'h0);
        tick(1'b0, 64'h0);
        chk("t5_pc_wrapped", pc_o, 64'h0);

        // 6: reset in the middle of traffic
        lat_min = 2; lat_max = 2; rdy_prob = 0;
        do_reset(); release_rst();
        repeat (4) tick(1'b0, 64'h0);
        do_reset();
        rdy_prob = 100;
        release_rst();
        chk("t6_req", imem_req_o, 1);
        chk("t6_addr", imem_addr_o, RST_PC);
        wait_valid("t6_valid_seen", 20);
        chk("t6_first_pc", pc_o, RST_PC);
        chk("t6_first_instr", instr_o, word(RST_PC));

        // randomized traffic, redirects and one mid-run reset
        do_reset(); release_rst();
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                gnt_prob = $urandom_range(100, 30);
                rv_prob  = $urandom_range(100, 30);
                lat_min  = 1;
                lat_max  = $urandom_range(6, 1);
                rdy_prob = $urandom_range(100, 10);
            end
            if (i == 2000) begin do_reset(); release_rst(); end
            tick($urandom_range(99) < 4, rand_target());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog expired");
    end
endmodule
